// File: rtl/imem_sched_pkg.sv
// Shared types and constants for the instruction-memory port scheduler.
package imem_sched_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned IMEM_BYTES = 256;
  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_LOAD  = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter2
  import imem_sched_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic req_fetch,
  input  logic req_load,
  output logic gnt_fetch_c,
  output logic gnt_load_c
);

  grant_e last_grant;

  always_comb begin
    gnt_fetch_c = 1'b0;
    gnt_load_c  = 1'b0;
    if (enable) begin
      gnt_fetch_c = req_fetch && (!req_load || (last_grant == GRANT_LOAD));
      gnt_load_c  = req_load && !gnt_fetch_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GRANT_LOAD;
    end else if (gnt_fetch_c) begin
      last_grant <= GRANT_FETCH;
    end else if (gnt_load_c) begin
      last_grant <= GRANT_LOAD;
    end
  end

endmodule

// File: rtl/imem_port_scheduler.sv
// Shares the byte-wide instruction memory port between 4-byte fetches and
// single-byte loader writes.
module imem_port_scheduler
  import imem_sched_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [INSN_W-1:0]     fetch_instruction,
  input  logic                  load_req,
  input  logic [MEM_ADDR_W-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  load_ack,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INSN_BYTES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [INSN_W-1:0]     asm_q, asm_d;
  logic [INSN_W-1:0]     insn_d;
  logic                  fetch_valid_d, load_ack_d, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_d;
  logic [7:0]            mem_wdata_d;
  logic                  gnt_fetch_c, gnt_load_c;
  logic                  unused_fetch_addr_hi;

  // Upper fetch address bits are ignored; the memory is only 256 bytes.
  assign unused_fetch_addr_hi = ^fetch_addr[31:MEM_ADDR_W];

  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .enable      ((state_q == IDLE) && !reset),
    .req_fetch   (fetch_req),
    .req_load    (load_req),
    .gnt_fetch_c (gnt_fetch_c),
    .gnt_load_c  (gnt_load_c)
  );

  assign fetch_ready = gnt_fetch_c;

  // Next-state and next-output logic; bytes shift in big-endian order.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    base_d        = base_q;
    asm_d         = asm_q;
    insn_d        = fetch_instruction;
    fetch_valid_d = 1'b0;
    load_ack_d    = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    case (state_q)
      IDLE: begin
        if (gnt_fetch_c) begin
          base_d     = fetch_addr[MEM_ADDR_W-1:0];
          idx_d      = '0;
          mem_addr_d = fetch_addr[MEM_ADDR_W-1:0];
          state_d    = ISSUE;
        end else if (gnt_load_c) begin
          mem_addr_d  = load_addr;
          mem_wdata_d = load_data;
          mem_we_d    = 1'b1;
          load_ack_d  = 1'b1;
          state_d     = WRITE;
        end
      end
      ISSUE: begin
        // First capture is stale data; it is shifted out before completion.
        asm_d = {asm_q[INSN_W-9:0], mem_rdata};
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          mem_addr_d = base_q + MEM_ADDR_W'(idx_q + IDX_W'(1));
        end
      end
      DRAIN: begin
        insn_d        = {asm_q[INSN_W-9:0], mem_rdata};
        fetch_valid_d = 1'b1;
        state_d       = IDLE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      base_q            <= '0;
      asm_q             <= '0;
      fetch_instruction <= '0;
      fetch_valid       <= 1'b0;
      load_ack          <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      base_q            <= base_d;
      asm_q             <= asm_d;
      fetch_instruction <= insn_d;
      fetch_valid       <= fetch_valid_d;
      load_ack          <= load_ack_d;
      mem_we            <= mem_we_d;
      mem_addr          <= mem_addr_d;
      mem_wdata         <= mem_wdata_d;
    end
  end

endmodule
